reg_exe_stage: RTL
==================

REG_EXE_STAGE -- requirements
Module: reg_exe_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand width.
REQ-002 Parameter OP_W, default 4, ALU opcode width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 valid_in, Ra_in[3:0], RE_A_in, Rb_in[3:0], RE_B_in, Robj_in[3:0], WE_in, mem_WE_in, mem_RE_in  in  decoded Reg-stage instruction fields.
REQ-006 alu_op_in  in  OP_W, plus A_in and B_in  in  DATA_W: opcode and register-file operands.
REQ-007 flush  in  1  branch taken in Exe; kill the Reg-stage instruction.
REQ-008 mem_busy  in  1  data memory not ready; freeze the stage.
REQ-009 valid_out, Ra_Reg_Exe, RE_A_Reg_Exe, Rb_Reg_Exe, RE_B_Reg_Exe, Robj_Reg_Exe, WE_Reg_Exe, mem_WE_Reg_Exe, mem_RE_Reg_Exe, alu_op_Reg_Exe, A_Reg_Exe, B_Reg_Exe  out  registered copies of the REQ-005/006 fields, consumed by the forwarding unit and Exe.
REQ-010 stall_F  out  1  combinational; hold the PC and the F/Reg register this cycle.
REQ-011 stall_cnt  out  16  stall-cycle counter (see Configuration).

Function
REQ-012 The load-use hazard lu SHALL be valid_out & mem_RE_Reg_Exe & valid_in & ((RE_A_in & Ra_in==Robj_Reg_Exe) | (RE_B_in & Rb_in==Robj_Reg_Exe)).
REQ-013 FSM states SHALL be RUN, BUBBLE and HOLD; reset state is RUN.
REQ-014 Per-cycle priority SHALL be mem_busy > flush > lu > normal load.
REQ-015 With mem_busy=1, the stage SHALL enter HOLD, keep every output register unchanged and drive stall_F=1.
REQ-016 In HOLD with mem_busy=0, the stage SHALL evaluate REQ-014 as in RUN on that same cycle.
REQ-017 With flush=1 (mem_busy=0), the stage SHALL load a bubble next edge (valid_out=0; all RE/WE/mem_* =0; fields otherwise unchanged) and drive stall_F=0.
REQ-018 With lu=1 (no flush, no mem_busy), the stage SHALL drive stall_F=1, load a bubble next edge and enter BUBBLE.
REQ-019 In BUBBLE, the held Reg instruction SHALL load normally next edge, with stall_F=0 and return to RUN.
REQ-020 At most one bubble SHALL be inserted per load; the WB-stage forward covers the remaining distance.
REQ-021 Normal load SHALL capture all inputs with latency 1; valid_in=0 loads a bubble.
REQ-022 A load followed by a dependent store (mem_WE_in, data register Ra_in) SHALL stall as in REQ-012.
REQ-023 Comparisons against a bubble (valid_out=0) SHALL never raise lu.

Reset
REQ-024 On rst_n=0, all outputs SHALL be 0 immediately, FSM=RUN and stall_cnt=0.
REQ-025 Reset asserted mid-BUBBLE or mid-HOLD SHALL discard the pending instruction.

Configuration
REQ-026 With STALL_CNT_EN defined, stall_cnt SHALL increment once per cycle with stall_F=1 and saturate at 16'hFFFF.
REQ-027 Without STALL_CNT_EN, stall_cnt SHALL be constant 0 and the counter SHALL not be synthesised.

Structure
REQ-028 Package proc_pkg SHALL hold REG_ADDR_W=4, OP_W, and the FSM state enum.
REQ-029 The lu comparator SHALL be a combinational sub-module load_use_detect.

Verification
REQ-030 LD R1 then ADD R2,R1,R3 -> stall_F=1 for 1 cycle, one valid_out=0 bubble, ADD in Exe one cycle later with Ra_Reg_Exe=1.
REQ-031 LD R1 then ADD R2,R4,R5 -> no stall, back-to-back valid_out=1.
REQ-032 lu and flush in the same cycle -> stall_F=0, bubble loaded, FSM stays RUN.
REQ-033 mem_busy=1 for 3 cycles with A_in changing -> A_Reg_Exe unchanged, stall_F=1 ×3; with STALL_CNT_EN, stall_cnt=3.
REQ-034 rst_n pulled low in BUBBLE -> outputs 0 asynchronously; after release, first valid_in=1 instruction appears after 1 cycle.
REQ-035 With STALL_CNT_EN, preload 16'hFFFE, then 3 stall cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths and Reg/Exe stage FSM encoding
package proc_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int OP_W       = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an incoming instruction that reads the destination of a load sitting in Exe
module load_use_detect
  import proc_pkg::*;
(
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_re,
  input  logic [REG_ADDR_W-1:0] i_ex_robj,
  input  logic                  i_rg_valid,
  input  logic                  i_rg_re_a,
  input  logic [REG_ADDR_W-1:0] i_rg_ra,
  input  logic                  i_rg_re_b,
  input  logic [REG_ADDR_W-1:0] i_rg_rb,
  output logic                  o_lu
);

  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a = i_rg_re_a && (i_rg_ra == i_ex_robj);
  assign w_hit_b = i_rg_re_b && (i_rg_rb == i_ex_robj);
  assign o_lu    = i_ex_valid && i_ex_mem_re && i_rg_valid && (w_hit_a || w_hit_b);

endmodule

// File: rtl/reg_exe_stage.sv
// rtl/reg_exe_stage.sv - Reg/Exe pipeline register with load-use bubble, flush and memory-busy hold
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module reg_exe_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = proc_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [REG_ADDR_W-1:0] Ra_in,
  input  logic                  RE_A_in,
  input  logic [REG_ADDR_W-1:0] Rb_in,
  input  logic                  RE_B_in,
  input  logic [REG_ADDR_W-1:0] Robj_in,
  input  logic                  WE_in,
  input  logic                  mem_WE_in,
  input  logic                  mem_RE_in,
  input  logic [OP_W-1:0]       alu_op_in,
  input  logic [DATA_W-1:0]     A_in,
  input  logic [DATA_W-1:0]     B_in,
  input  logic                  flush,
  input  logic                  mem_busy,
  output logic                  valid_out,
  output logic [REG_ADDR_W-1:0] Ra_Reg_Exe,
  output logic                  RE_A_Reg_Exe,
  output logic [REG_ADDR_W-1:0] Rb_Reg_Exe,
  output logic                  RE_B_Reg_Exe,
  output logic [REG_ADDR_W-1:0] Robj_Reg_Exe,
  output logic                  WE_Reg_Exe,
  output logic                  mem_WE_Reg_Exe,
  output logic                  mem_RE_Reg_Exe,
  output logic [OP_W-1:0]       alu_op_Reg_Exe,
  output logic [DATA_W-1:0]     A_Reg_Exe,
  output logic [DATA_W-1:0]     B_Reg_Exe,
  output logic                  stall_F,
  output logic [15:0]           stall_cnt
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_lu;
  logic                  w_load;
  logic                  w_bubble;
  logic                  w_stall;

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_ra;
  logic                  r_re_a;
  logic [REG_ADDR_W-1:0] r_rb;
  logic                  r_re_b;
  logic [REG_ADDR_W-1:0] r_robj;
  logic                  r_we;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic [OP_W-1:0]       r_alu_op;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;

  load_use_detect u_lud (
    .i_ex_valid  (r_valid),
    .i_ex_mem_re (r_mem_re),
    .i_ex_robj   (r_robj),
    .i_rg_valid  (valid_in),
    .i_rg_re_a   (RE_A_in),
    .i_rg_ra     (Ra_in),
    .i_rg_re_b   (RE_B_in),
    .i_rg_rb     (Rb_in),
    .o_lu        (w_lu)
  );

  // Exe holds a bubble while in BUBBLE, so a second stall for the same load cannot occur.
  always_comb begin
    w_state_nxt = RUN;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_stall     = 1'b0;
    if (mem_busy) begin
      w_state_nxt = HOLD;
      w_stall     = 1'b1;
    end else if (flush) begin
      w_bubble    = 1'b1;
    end else if (w_lu && (r_state != BUBBLE)) begin
      w_state_nxt = BUBBLE;
      w_stall     = 1'b1;
      w_bubble    = 1'b1;
    end else if (valid_in) begin
      w_load      = 1'b1;
    end else begin
      w_bubble    = 1'b1;
    end
  end

  assign stall_F = rst_n && w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_valid  <= 1'b0;
      r_ra     <= '0;
      r_re_a   <= 1'b0;
      r_rb     <= '0;
      r_re_b   <= 1'b0;
      r_robj   <= '0;
      r_we     <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_alu_op <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_ra     <= Ra_in;
        r_re_a   <= RE_A_in;
        r_rb     <= Rb_in;
        r_re_b   <= RE_B_in;
        r_robj   <= Robj_in;
        r_we     <= WE_in;
        r_mem_we <= mem_WE_in;
        r_mem_re <= mem_RE_in;
        r_alu_op <= alu_op_in;
        r_a      <= A_in;
        r_b      <= B_in;
      end else if (w_bubble) begin
        r_valid  <= 1'b0;
        r_re_a   <= 1'b0;
        r_re_b   <= 1'b0;
        r_we     <= 1'b0;
        r_mem_we <= 1'b0;
        r_mem_re <= 1'b0;
      end
    end
  end

  assign valid_out      = r_valid;
  assign Ra_Reg_Exe     = r_ra;
  assign RE_A_Reg_Exe   = r_re_a;
  assign Rb_Reg_Exe     = r_rb;
  assign RE_B_Reg_Exe   = r_re_b;
  assign Robj_Reg_Exe   = r_robj;
  assign WE_Reg_Exe     = r_we;
  assign mem_WE_Reg_Exe = r_mem_we;
  assign mem_RE_Reg_Exe = r_mem_re;
  assign alu_op_Reg_Exe = r_alu_op;
  assign A_Reg_Exe      = r_a;
  assign B_Reg_Exe      = r_b;

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (stall_F && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
